popcount_pipe: RTL and testbench

Pipelined, elastic population counter: counts the set bits of an `INPUT_WIDTH`-bit word through an adder tree with a register every `LEVELS_PER_STAGE` tree levels. Each end uses a valid/ready handshake. The block sustains one word per cycle and stalls without losing or duplicating data. An optional running accumulator sums counts across a framed burst. It sits in streaming datapaths, such as bitmap or sparsity-mask statistics, where a combinational popcount of wide words cannot close timing.

---
 rtl/popcount_pipe_pkg.sv | 28 ++
 rtl/popcount_pipe_stage.sv | 93 +++++++++
 rtl/popcount_pipe.sv | 130 +++++++++++++
 tb/tb_popcount_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pipe_pkg.sv
// Shared helpers for the pipelined population counter.
//   pc_stages      : number of register stages for a given word width and
//                    number of adder-tree levels per stage
//   pc_level_width : width of a partial sum at a tree level (level 0 = raw bits)
//   pc_sat_add     : unsigned add clamped to the largest w-bit value (w <= 64)
package popcount_pipe_pkg;

   function automatic int pc_stages(input int width, input int levels);
      int depth;
      depth = $clog2(width);
      return (depth + levels - 1) / levels;
   endfunction

   function automatic int pc_level_width(input int level);
      return level + 1;
   endfunction

   function automatic logic [63:0] pc_sat_add(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input int          w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (sum > lim) ? 64'(lim) : 64'(sum);
   endfunction

endpackage

// File: rtl/popcount_pipe_stage.sv
// One registered elastic slice of the popcount adder tree.
// Reduces IN_COUNT partial sums of level IN_LEVEL by N_LEVELS levels of
// pairwise addition and registers the result.
// Optional macro: POPCOUNT_PIPE_ACCUM_EN carries a 'last' flag with the data.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   up_valid/up_ready   upstream handshake (up_ready = load condition)
//   up_data             IN_COUNT partial sums, IN_W bits each, packed
//   up_last             burst marker (accumulator build only)
//   dn_valid/dn_ready   downstream handshake
//   dn_data             OUT_COUNT partial sums, OUT_W bits each, packed
//   dn_last             registered burst marker (accumulator build only)
module popcount_pipe_stage
   import popcount_pipe_pkg::*;
#(
   parameter  int IN_LEVEL  = 0,
   parameter  int N_LEVELS  = 1,
   parameter  int IN_COUNT  = 2,
   localparam int IN_W      = pc_level_width(IN_LEVEL),
   localparam int OUT_W     = pc_level_width(IN_LEVEL + N_LEVELS),
   localparam int OUT_COUNT = IN_COUNT >> N_LEVELS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           up_valid,
   output logic                           up_ready,
   input  logic [IN_COUNT*IN_W-1:0]       up_data,
`ifdef POPCOUNT_PIPE_ACCUM_EN
   input  logic                           up_last,
   output logic                           dn_last,
`endif
   output logic                           dn_valid,
   input  logic                           dn_ready,
   output logic [OUT_COUNT*OUT_W-1:0]     dn_data
);

   logic                       load;
   logic                       vld_p1;
   logic [OUT_COUNT*OUT_W-1:0] sum_p1;
   logic [OUT_COUNT*OUT_W-1:0] sum_flat;

   // Load when empty or when the held word is leaving this cycle.
   assign load     = !vld_p1 || dn_ready;
   assign up_ready = load;

   // Each tree level widens by one bit, so no sum is ever truncated.
   for (genvar j = 0; j <= N_LEVELS; j++) begin : lev
      localparam int CNT = IN_COUNT >> j;
      localparam int W   = pc_level_width(IN_LEVEL + j);
      logic [W-1:0] s [CNT];
      if (j == 0) begin : g_leaf
         for (genvar i = 0; i < CNT; i++) begin : g_in
            assign s[i] = up_data[i*W +: W];
         end
      end else begin : g_add
         for (genvar i = 0; i < CNT; i++) begin : g_pair
            assign s[i] = {1'b0, lev[j-1].s[2*i]} + {1'b0, lev[j-1].s[2*i+1]};
         end
      end
   end

   for (genvar i = 0; i < OUT_COUNT; i++) begin : g_flat
      assign sum_flat[i*OUT_W +: OUT_W] = lev[N_LEVELS].s[i];
   end

   // ---- stage register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         sum_p1 <= '0;
      end else if (load) begin
         vld_p1 <= up_valid;
         // Bubbles leave the data register untouched.
         if (up_valid) sum_p1 <= sum_flat;
      end
   end

`ifdef POPCOUNT_PIPE_ACCUM_EN
   logic last_p1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_p1 <= 1'b0;
      end else if (load && up_valid) begin
         last_p1 <= up_last;
      end
   end
   assign dn_last = last_p1;
`endif

   assign dn_valid = vld_p1;
   assign dn_data  = sum_p1;

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined, elastic population counter. The word is zero-padded to a power
// of two and reduced by an adder tree with a register every LEVELS_PER_STAGE
// levels; each stage is a valid/ready slice, so the pipe holds S words and
// sustains one word per cycle.
// Optional macro: POPCOUNT_PIPE_ACCUM_EN adds last_i/last_o and a saturating
// running sum acc_o over each burst (cleared after the beat marked last).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   valid_i/ready_o       input handshake, data_i sampled on it
//   data_i                INPUT_WIDTH-bit word
//   last_i                burst end marker (accumulator build only)
//   valid_o/ready_i       output handshake
//   popcount_o            number of set bits, $clog2(INPUT_WIDTH)+1 bits
//   last_o                last_i of that word (accumulator build only)
//   acc_o                 saturating burst sum incl. current beat (accumulator build only)
module popcount_pipe
   import popcount_pipe_pkg::*;
#(
   parameter int INPUT_WIDTH      = 256,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int ACC_WIDTH        = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [INPUT_WIDTH-1:0]       data_i,
`ifdef POPCOUNT_PIPE_ACCUM_EN
   input  logic                         last_i,
   output logic                         last_o,
   output logic [ACC_WIDTH-1:0]         acc_o,
`endif
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [$clog2(INPUT_WIDTH):0] popcount_o
);

   localparam int D = $clog2(INPUT_WIDTH);
   localparam int P = 1 << D;
   localparam int S = pc_stages(INPUT_WIDTH, LEVELS_PER_STAGE);

   if (INPUT_WIDTH < 2 || LEVELS_PER_STAGE < 1 || ACC_WIDTH < 1 || ACC_WIDTH > 64) begin : g_param_check
      $error("popcount_pipe: illegal parameter value");
   end

   logic [P-1:0] padded;
   assign padded = P'(data_i);

   for (genvar k = 0; k < S; k++) begin : stg
      localparam int IN_LEVEL = k * LEVELS_PER_STAGE;
      // The final slice takes whatever levels remain.
      localparam int NLV      = (D - IN_LEVEL < LEVELS_PER_STAGE) ? (D - IN_LEVEL) : LEVELS_PER_STAGE;
      localparam int IN_COUNT = P >> IN_LEVEL;
      localparam int IN_BITS  = IN_COUNT * pc_level_width(IN_LEVEL);
      localparam int OUT_BITS = (IN_COUNT >> NLV) * pc_level_width(IN_LEVEL + NLV);

      logic                up_rdy;
      logic                in_vld;
      logic                out_vld;
      logic                dn_rdy;
      logic [IN_BITS-1:0]  din;
      logic [OUT_BITS-1:0] dout;
`ifdef POPCOUNT_PIPE_ACCUM_EN
      logic                in_last;
      logic                out_last;
`endif

      if (k == 0) begin : g_src
         assign in_vld = valid_i;
         assign din    = padded;
`ifdef POPCOUNT_PIPE_ACCUM_EN
         assign in_last = last_i;
`endif
      end else begin : g_chain
         assign in_vld = stg[k-1].out_vld;
         assign din    = stg[k-1].dout;
`ifdef POPCOUNT_PIPE_ACCUM_EN
         assign in_last = stg[k-1].out_last;
`endif
      end

      // Stage k may replace its word when stage k+1 loads (or the output is taken).
      if (k == S - 1) begin : g_sink
         assign dn_rdy = ready_i;
      end else begin : g_next
         assign dn_rdy = stg[k+1].up_rdy;
      end

      popcount_pipe_stage #(
         .IN_LEVEL (IN_LEVEL),
         .N_LEVELS (NLV),
         .IN_COUNT (IN_COUNT)
      ) u_stage (
         .clk      (clk_i),
         .rst      (rst_i),
         .up_valid (in_vld),
         .up_ready (up_rdy),
         .up_data  (din),
`ifdef POPCOUNT_PIPE_ACCUM_EN
         .up_last  (in_last),
         .dn_last  (out_last),
`endif
         .dn_valid (out_vld),
         .dn_ready (dn_rdy),
         .dn_data  (dout)
      );
   end

   assign ready_o    = stg[0].up_rdy;
   assign valid_o    = stg[S-1].out_vld;
   assign popcount_o = stg[S-1].dout;

`ifdef POPCOUNT_PIPE_ACCUM_EN
   logic [ACC_WIDTH-1:0] acc_q;

   assign last_o = stg[S-1].out_last;
   // Includes the beat currently presented; clamps instead of wrapping.
   assign acc_o  = ACC_WIDTH'(pc_sat_add(64'(acc_q), 64'(popcount_o), ACC_WIDTH));

   // ---- accumulator register ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else if (valid_o && ready_i) begin
         acc_q <= last_o ? '0 : acc_o;
      end
   end
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
module tb_popcount_pipe;

   localparam int W  = 256;
   localparam int S  = 4;
   localparam int W5 = 5;
   localparam int S5 = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid_i = 1'b0;
   logic         ready_i = 1'b1;
   logic [W-1:0] data_i = '0;
   logic         ready_o;
   logic         valid_o;
   logic [8:0]   popcount_o;

   logic         v5 = 1'b0;
   logic [4:0]   d5 = '0;
   logic         r5;
   logic         vo5;
   logic [3:0]   pc5;
`ifdef POPCOUNT_PIPE_ACCUM_EN
   logic         last_i = 1'b0;
   logic         last_o;
   logic [31:0]  acc_o;
   logic         l5 = 1'b0;
   logic         lo5;
   logic [7:0]   acc5;
`endif

   always #5 clk = ~clk;

   popcount_pipe #(.INPUT_WIDTH(W), .LEVELS_PER_STAGE(2), .ACC_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
`ifdef POPCOUNT_PIPE_ACCUM_EN
      .last_i(last_i), .last_o(last_o), .acc_o(acc_o),
`endif
      .valid_o(valid_o), .ready_i(ready_i), .popcount_o(popcount_o));

   popcount_pipe #(.INPUT_WIDTH(W5), .LEVELS_PER_STAGE(1), .ACC_WIDTH(8)) dut5 (
      .clk_i(clk), .rst_i(rst), .valid_i(v5), .ready_o(r5), .data_i(d5),
`ifdef POPCOUNT_PIPE_ACCUM_EN
      .last_i(l5), .last_o(lo5), .acc_o(acc5),
`endif
      .valid_o(vo5), .ready_i(1'b1), .popcount_o(pc5));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int ones_cnt(input logic [W-1:0] d);
      int c = 0;
      for (int i = 0; i < W; i++) c += int'(d[i]);
      return c;
   endfunction

   function automatic logic [W-1:0] ones(input int n);
      logic [W-1:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic longint sat(input longint v, input int aw);
      longint mx = (longint'(1) << aw) - 1;
      return (v > mx) ? mx : v;
   endfunction

   typedef struct {
      int cnt;
      bit last;
      int t;
   } item_t;

   item_t  q[$];
   item_t  q5[$];
   longint acc_m  = 0;
   longint acc_m5 = 0;
   int     ncyc   = 0;
   bit     chk_lat = 1'b0;
   int     rdy_mode = 0;

   always @(posedge clk) ncyc++;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       ready_i = 1'b1;
         1:       ready_i = 1'b0;
         default: ready_i = ($urandom_range(0, 3) != 0);
      endcase
   end

   always @(negedge clk) begin
      item_t  it;
      longint ea;
      if (rst) begin
         q.delete();
         acc_m = 0;
      end else begin
         if (valid_o) begin
            if (q.size() == 0) check("out_without_in", valid_o, 1'b0);
            else begin
               check("popcount", popcount_o, q[0].cnt);
               ea = sat(acc_m + q[0].cnt, 32);
`ifdef POPCOUNT_PIPE_ACCUM_EN
               check("last", last_o, q[0].last);
               check("acc", acc_o, ea);
`endif
               if (ready_i) begin
                  if (chk_lat) check("latency", ncyc - q[0].t, S);
                  acc_m = q[0].last ? 0 : ea;
                  void'(q.pop_front());
               end
            end
         end
         if (valid_i && ready_o) begin
            it.cnt = ones_cnt(data_i);
            it.last = 1'b0;
`ifdef POPCOUNT_PIPE_ACCUM_EN
            it.last = last_i;
`endif
            it.t = ncyc;
            q.push_back(it);
         end
      end
   end

   always @(negedge clk) begin
      item_t  it;
      longint ea;
      if (rst) begin
         q5.delete();
         acc_m5 = 0;
      end else begin
         if (vo5) begin
            if (q5.size() == 0) check("w5_out_without_in", vo5, 1'b0);
            else begin
               check("w5_popcount", pc5, q5[0].cnt);
               check("w5_latency", ncyc - q5[0].t, S5);
               ea = sat(acc_m5 + q5[0].cnt, 8);
`ifdef POPCOUNT_PIPE_ACCUM_EN
               check("w5_acc", acc5, ea);
`endif
               acc_m5 = ea;
               void'(q5.pop_front());
            end
         end
         if (v5 && r5) begin
            it.cnt = ones_cnt(W'(d5));
            it.last = 1'b0;
            it.t = ncyc;
            q5.push_back(it);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [W-1:0] d, input bit lst);
      valid_i = 1'b1;
      data_i  = d;
`ifdef POPCOUNT_PIPE_ACCUM_EN
      last_i  = lst;
`else
      if (lst) data_i = d;
`endif
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (ready_o) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      check("send_timeout", ready_o, 1'b1);
      valid_i = 1'b0;
   endtask

   task automatic set_rdy(input int m);
      @(negedge clk);
      rdy_mode = m;
      @(posedge clk); #1;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q.size() == 0 && q5.size() == 0 && !valid_o && !vo5) break;
      end
      check("drain_pending", q.size() + q5.size(), 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
      case ($urandom_range(0, 7))
         0:       r = '0;
         1:       r = '1;
         2:       r = r & {W/32{$urandom()}};
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      logic [W-1:0] pat_a;
      int accepted;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready_o", ready_o, 1'b1);
      check("rst_valid_o", valid_o, 1'b0);
      check("rst_popcount", popcount_o, 0);
`ifdef POPCOUNT_PIPE_ACCUM_EN
      check("rst_last_o", last_o, 1'b0);
      check("rst_acc_o", acc_o, 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back directed words with fixed latency.
      for (int i = 0; i < W / 4; i++) pat_a[i*4 +: 4] = 4'hA;
      chk_lat = 1'b1;
      send('0, 1'b0);
      send('1, 1'b0);
      send(pat_a, 1'b1);
      wait_empty();
      chk_lat = 1'b0;

      // Full stall: pipe fills with exactly S words, results held.
      set_rdy(1);
      accepted = 0;
      valid_i = 1'b1;
      data_i = rnd_word();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ready_o) accepted++;
         @(posedge clk); #1;
         if (ready_o || accepted > 0) data_i = rnd_word();
      end
      valid_i = 1'b0;
      check("stall_accepted", accepted, S);
      check("stall_ready_o", ready_o, 1'b0);
      set_rdy(0);
      wait_empty();
      send('0, 1'b1);
      wait_empty();

      // Burst accumulation 3,5,7(last) then 2(last).
      send(ones(3), 1'b0);
      send(ones(5), 1'b0);
      send(ones(7), 1'b1);
      send(ones(2), 1'b1);
      wait_empty();

      // Random traffic with random backpressure and bursts.
      set_rdy(2);
      for (int i = 0; i < 300; i++) begin
         send(rnd_word(), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         #0;
      end
      set_rdy(0);
      wait_empty();

      // Reset with three words in flight and a partial sum.
      send(ones(10), 1'b0);
      wait_empty();
      set_rdy(1);
      send(ones(20), 1'b0);
      send(ones(30), 1'b0);
      send(ones(40), 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_valid_o", valid_o, 1'b0);
      check("midrst_ready_o", ready_o, 1'b1);
`ifdef POPCOUNT_PIPE_ACCUM_EN
      check("midrst_acc_o", acc_o, 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      set_rdy(0);
      send(ones(6), 1'b1);
      wait_empty();

      // Narrow, non-power-of-two instance: first 10111, then saturation.
      v5 = 1'b1;
      d5 = 5'b10111;
      @(posedge clk); #1;
      for (int i = 0; i < 60; i++) begin
         d5 = 5'b11111;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 20; i++) begin
         d5 = 5'($urandom());
         @(posedge clk); #1;
      end
      v5 = 1'b0;
      wait_empty();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
